booth_mult_ctrl: RTL
====================

Name: booth_mult_ctrl

Overview:
- Sequencer and adder stage for the 32x32 signed radix-2 Booth multiplier.
- Drives the 64-bit product register (load/shift register with helper bit) and consumes its state: prod_q and the two Booth bits prod_lsb = {q[0], helper}.
- Accepts operands on a start pulse and runs 32 add/sub-and-shift iterations.
- Returns the low 32-bit product with a signed-overflow flag to the processor's multdiv unit.

Parameters:
- WIDTH, 32, operand width; the product register is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- start_mult  in  1  one-cycle request; sampled only in IDLE
- multiplicand  in  WIDTH  signed operand, latched on accepted start
- multiplier  in  WIDTH  signed operand, loaded into the product register low half on accepted start
- prod_q  in  2*WIDTH  current product register contents
- prod_lsb  in  2  {prod_q[0], helper bit} Booth decision bits
- prod_d  out  2*WIDTH  next-value data to the product register
- prod_start  out  1  1 = register loads prod_d verbatim and clears helper; 0 = register loads arithmetic-right-shift-by-1 of prod_d, helper <= prod_d[0]
- prod_ena  out  1  product register write enable
- busy  out  1  high from accepted start until result_rdy
- result  out  WIDTH  low WIDTH bits of the product, held until next accepted start
- ovf  out  1  result does not fit in WIDTH signed bits; held with result
- result_rdy  out  1  one-cycle pulse; result/ovf valid

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE, counter=0, latched multiplicand=0, result=0, ovf=0, result_rdy=0, busy=0. Mealy outputs prod_ena=0, prod_start=0, prod_d=0.
- Reset mid-operation aborts immediately. No result_rdy is produced. The next start after release runs a full operation.
- States:
  - IDLE -> ITER: on start_mult=1.
  - ITER -> DONE: when counter==WIDTH-1 at the clock edge.
  - DONE -> IDLE: unconditionally.
- IDLE with start_mult=1, same cycle (combinational outputs):
  - prod_ena=1, prod_start=1, prod_d={WIDTH'b0, multiplier}.
  - On the clock edge: latch multiplicand, counter<=0, busy<=1.
- ITER, every cycle: prod_ena=1, prod_start=0, counter increments on each edge.
  - prod_d[WIDTH-1:0] = prod_q[WIDTH-1:0].
  - prod_d[2*WIDTH-1:WIDTH] by prod_lsb:
    - 00 or 11: upper half of prod_q unchanged.
    - 01: upper half of prod_q + mcand.
    - 10: upper half of prod_q - mcand.
  - Add and subtract are WIDTH-bit two's complement with wrap-around; the carry is discarded.
  - Exactly WIDTH iterations occur.
- DONE, one cycle: prod_ena=0. On the edge:
  - result <= prod_q[WIDTH-1:0].
  - result_rdy <= 1 for exactly one cycle.
  - busy <= 0.
- Overflow: ovf=1 if either condition holds.
  - prod_q[2*WIDTH-1:WIDTH] != {WIDTH{prod_q[WIDTH-1]}}.
  - mcand==0x80000000 and multiplier not in {0, 1}. This compensates for the WIDTH-bit adder sign error; the low word is always correct.
- Latency: start accepted at edge 0; result_rdy high in the cycle following edge WIDTH+1 (33 cycles for WIDTH=32).
- The next start may be accepted in the cycle result_rdy is high (state is already IDLE).
- start_mult while busy: ignored, no effect on operands or count.
- Operand inputs are don't-care except in the accepting cycle.

Test Plan:
- Setup: bench instantiates this block with the product register model connected and checks every result.
- 7 x 6, start pulse -> busy for 33 cycles; result_rdy one cycle; result=0x0000002A, ovf=0.
- -3 x 5 -> result=0xFFFFFFF1, ovf=0; then 0x00010000 x 0x00010000 back-to-back (start in the result_rdy cycle) -> result=0x00000000, ovf=1.
- 0x80000000 x 1 -> result=0x80000000, ovf=0; 0x80000000 x 0xFFFFFFFF -> result=0x80000000, ovf=1; 0x80000000 x 0 -> result=0, ovf=0.
- start_mult re-pulsed with operands 9 x 9 at iteration 10 of a 12 x 12 operation -> ignored; result=0x00000090 at cycle 33.
- clrn low at iteration 15 of 100 x 100 -> result=0, ovf=0, busy=0 asynchronously, no result_rdy; next 2 x 3 -> result=6 after 33 cycles.

Source files
------------

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: sequencer and adder stage for a radix-2 Booth signed multiplier
module booth_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 start_mult,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [2*WIDTH-1:0]   prod_q,
  input  logic [1:0]           prod_lsb,
  output logic [2*WIDTH-1:0]   prod_d,
  output logic                 prod_start,
  output logic                 prod_ena,
  output logic                 busy,
  output logic [WIDTH-1:0]     result,
  output logic                 ovf,
  output logic                 result_rdy
);
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand, r_result;
  logic               r_mplr_wide, r_busy, r_ovf, r_rdy;
  logic [WIDTH-1:0]   w_hi, w_acc;
  logic               w_accept, w_last, w_ovf;
  assign w_hi     = prod_q[2*WIDTH-1:WIDTH];
  assign w_accept = (r_state == S_IDLE) && start_mult;
  assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
  assign w_acc    = (prod_lsb == 2'b01) ? w_hi + r_mcand :
                    (prod_lsb == 2'b10) ? w_hi - r_mcand : w_hi;
  // The WIDTH-bit adder corrupts the high word when mcand is the most negative value;
  // such a product only fits when the multiplier is 0 or 1.
  assign w_ovf    = (r_mcand == {1'b1, {(WIDTH-1){1'b0}}}) ? r_mplr_wide :
                    (w_hi != {WIDTH{prod_q[WIDTH-1]}});
  assign busy       = r_busy;
  assign result     = r_result;
  assign ovf        = r_ovf;
  assign result_rdy = r_rdy;
  // state register
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) r_state <= S_IDLE;
    else       r_state <= w_next;
  // next-state logic
  always_comb
    w_next = (r_state == S_IDLE) ? (start_mult ? S_ITER : S_IDLE) :
             (r_state == S_ITER) ? (w_last ? S_DONE : S_ITER) : S_IDLE;
  // product register control: load operands on accept, add/sub-and-shift while iterating
  always_comb begin
    prod_ena   = w_accept || (r_state == S_ITER);
    prod_start = w_accept;
    prod_d     = w_accept ? {{WIDTH{1'b0}}, multiplier} :
                 (r_state == S_ITER) ? {w_acc, prod_q[WIDTH-1:0]} : '0;
  end
  // operand latch, iteration counter and result capture
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplr_wide <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= r_state == S_DONE;
      if (w_accept) begin
        r_cnt       <= '0;
        r_mcand     <= multiplicand;
        r_mplr_wide <= |multiplier[WIDTH-1:1];
        r_busy      <= 1'b1;
      end else if (r_state == S_ITER) r_cnt <= r_cnt + 1'b1;
      else if (r_state == S_DONE) begin
        r_result <= prod_q[WIDTH-1:0];
        r_ovf    <= w_ovf;
        r_busy   <= 1'b0;
      end
    end
endmodule
